// File: rtl/hamming_secded_dec.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshake,
// optional detect-only mode and saturating error-event counters.
module hamming_secded_dec #(
  parameter int DATA_W = 4,
  parameter int P_W    = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W+P_W:0]   in_cw,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  correct_en,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_sec,
  output logic                  out_ded,
  output logic [P_W-1:0]        out_pos,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      sec_cnt,
  output logic [CNT_W-1:0]      ded_cnt
);

  localparam int N = DATA_W + P_W + 1;
  localparam int M = DATA_W + P_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [P_W-1:0] calc_syn(input logic [N-1:0] cw);
    logic [P_W-1:0] s;
    s = '0;
    for (int k = 0; k < P_W; k++) begin
      for (int p = 1; p <= M; p++) begin
        if (p[k]) s[k] = s[k] ^ cw[p];
      end
    end
    return s;
  endfunction

  function automatic logic calc_op(input logic [N-1:0] cw);
    return ^cw;
  endfunction

  // Data bits fill non-power-of-two positions ascending, MSB first.
  function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] cw);
    logic [DATA_W-1:0] d;
    int idx;
    d   = '0;
    idx = DATA_W - 1;
    for (int p = 1; p <= M; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[idx] = cw[p];
        idx    = idx - 1;
      end
    end
    return d;
  endfunction

  function automatic logic [N-1:0] pos_mask(input logic [P_W-1:0] syn);
    logic [N-1:0] m;
    m = '0;
    for (int p = 0; p < N; p++) begin
      if (int'(syn) == p) m[p] = 1'b1;
    end
    return m;
  endfunction

  logic               s1_valid_r;
  logic [N-1:0]       s1_cw_r;
  logic               s1_cen_r;
  logic [P_W-1:0]     s1_syn_r;
  logic               s1_op_r;
  logic               s2_ready_s;
  logic               dec_sec_s;
  logic               dec_ded_s;
  logic [N-1:0]       fix_cw_s;
  logic [DATA_W-1:0]  dec_data_s;
  logic               out_hs_s;

  assign s2_ready_s = !out_valid || out_ready;
  assign in_ready   = !s1_valid_r || s2_ready_s;
  assign out_hs_s   = out_valid && out_ready;

  // Stage 1: capture word and its mode, compute syndrome and overall parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_cw_r    <= '0;
      s1_cen_r   <= 1'b0;
      s1_syn_r   <= '0;
      s1_op_r    <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_cw_r  <= in_cw;
        s1_cen_r <= correct_en;
        s1_syn_r <= calc_syn(in_cw);
        s1_op_r  <= calc_op(in_cw);
      end
    end
  end

  // Classify the stage-1 word and build the (optionally) corrected codeword.
  always_comb begin
    dec_sec_s = 1'b0;
    dec_ded_s = 1'b0;
    fix_cw_s  = s1_cw_r;
    case ({s1_op_r, (s1_syn_r != '0)})
      2'b00: dec_sec_s = 1'b0;
      2'b10: dec_sec_s = 1'b1;
      2'b11: begin
        if (int'(s1_syn_r) <= M) begin
          dec_sec_s = 1'b1;
          if (s1_cen_r) fix_cw_s = s1_cw_r ^ pos_mask(s1_syn_r);
          else          fix_cw_s = s1_cw_r;
        end else begin
          dec_ded_s = 1'b1;
        end
      end
      2'b01:   dec_ded_s = 1'b1;
      default: dec_ded_s = 1'b0;
    endcase
    dec_data_s = extract(fix_cw_s);
  end

  // Stage 2: output registers, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sec   <= 1'b0;
      out_ded   <= 1'b0;
      out_pos   <= '0;
    end else if (s2_ready_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data <= dec_data_s;
        out_sec  <= dec_sec_s;
        out_ded  <= dec_ded_s;
        out_pos  <= s1_syn_r;
      end
    end
  end

  // Saturating event counters; clear takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (clr_cnt) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (out_hs_s && out_sec && (sec_cnt != CNT_MAX)) sec_cnt <= sec_cnt + CNT_ONE;
      if (out_hs_s && out_ded && (ded_cnt != CNT_MAX)) ded_cnt <= ded_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Self-checking bench for hamming_secded_dec (DATA_W=4, P_W=3, CNT_W=2):
// table vectors, backpressured stream, counter saturation/clear, mid-stream reset.
module tb_hamming_secded_dec;

  typedef struct {
    logic [7:0] cw;
    logic       cen;
    logic [3:0] data;
    logic       sec;
    logic       ded;
    logic [2:0] pos;
    int         t;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_cw;
  logic       in_valid;
  logic       in_ready;
  logic       correct_en;
  logic [3:0] out_data;
  logic       out_sec;
  logic       out_ded;
  logic [2:0] out_pos;
  logic       out_valid;
  logic       out_ready;
  logic       clr_cnt;
  logic [1:0] sec_cnt;
  logic [1:0] ded_cnt;

  hamming_secded_dec #(.DATA_W(4), .P_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_cw(in_cw), .in_valid(in_valid),
    .in_ready(in_ready), .correct_en(correct_en), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .out_pos(out_pos),
    .out_valid(out_valid), .out_ready(out_ready), .clr_cnt(clr_cnt),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t tbl[8];
  vec_t strm[6];
  vec_t drv_vec;
  logic drv_valid = 1'b0;
  logic drv_ready = 1'b1;
  logic drv_clr   = 1'b0;
  logic accepted  = 1'b0;
  logic held_v    = 1'b0;
  logic [8:0] held;
  int   m_sc = 0;
  int   m_dc = 0;
  int   cyc = 0;
  int   last_lat = 0;
  int   n_out = 0;
  int   sent;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    c    = 8'h00;
    c[3] = d[3]; c[5] = d[2]; c[6] = d[1]; c[7] = d[0];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    c[0] = ^c[7:1];
    return c;
  endfunction

  // One clock cycle: drive at negedge, check settled values, then take the edge.
  task automatic step();
    logic hs;
    logic got;
    vec_t e;
    vec_t a;
    got = 1'b0;
    @(negedge clk);
    in_valid   = drv_valid;
    in_cw      = drv_vec.cw;
    correct_en = drv_vec.cen;
    out_ready  = drv_ready;
    clr_cnt    = drv_clr;
    #1;
    chk("sec_cnt", sec_cnt, m_sc);
    chk("ded_cnt", ded_cnt, m_dc);
    chk("in_ready", in_ready, (exp_q.size() == 2 && !out_ready) ? 0 : 1);
    if (held_v) chk("stall_hold", {out_valid, out_data, out_sec, out_ded, out_pos}, {1'b1, held});
    hs = out_valid && out_ready;
    if (hs) begin
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = 1'b1;
        n_out++;
        chk("out_data", out_data, e.data);
        chk("out_sec", out_sec, e.sec);
        chk("out_ded", out_ded, e.ded);
        chk("out_pos", out_pos, e.pos);
        last_lat = cyc - e.t;
      end
    end
    if (drv_clr) begin
      m_sc = 0;
      m_dc = 0;
    end else if (got) begin
      if (e.sec && m_sc < 3) m_sc++;
      if (e.ded && m_dc < 3) m_dc++;
    end
    held_v   = out_valid && !out_ready;
    held     = {out_data, out_sec, out_ded, out_pos};
    accepted = in_valid && in_ready;
    if (accepted) begin
      a   = drv_vec;
      a.t = cyc;
      exp_q.push_back(a);
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic send(input vec_t v);
    int i;
    drv_valid = 1'b1;
    drv_vec   = v;
    i = 0;
    do begin
      step();
      i++;
    end while (!accepted && i < 30);
    chk("accept_timeout", accepted, 1);
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic vec_t mk(input logic [7:0] cw, input logic cen, input logic [3:0] d,
                              input logic s, input logic dd, input logic [2:0] p);
    vec_t v;
    v.cw = cw; v.cen = cen; v.data = d; v.sec = s; v.ded = dd; v.pos = p; v.t = 0;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(8'hCC, 1'b1, 4'hB, 1'b0, 1'b0, 3'd0);
    tbl[1] = mk(8'hEC, 1'b1, 4'hB, 1'b1, 1'b0, 3'd5);
    tbl[2] = mk(8'hEC, 1'b0, 4'hF, 1'b1, 1'b0, 3'd5);
    tbl[3] = mk(8'hCD, 1'b1, 4'hB, 1'b1, 1'b0, 3'd0);
    tbl[4] = mk(8'hCA, 1'b1, 4'hB, 1'b0, 1'b1, 3'd3);
    tbl[5] = mk(8'h4C, 1'b1, 4'hB, 1'b1, 1'b0, 3'd7);
    tbl[6] = mk(8'h4C, 1'b0, 4'hA, 1'b1, 1'b0, 3'd7);
    tbl[7] = mk(8'hC5, 1'b1, 4'h3, 1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] d;
      int         e;
      logic [7:0] c;
      d = 4'($urandom_range(0, 15));
      e = (i == 0) ? 8 : int'($urandom_range(0, 8));
      c = enc(d);
      if (e < 8) c[e] = ~c[e];
      strm[i] = mk(c, 1'b1, d, (e < 8), 1'b0, (e < 8) ? 3'(e) : 3'd0);
    end
    drv_vec = tbl[0];

    rst_n = 1'b0; in_valid = 1'b0; in_cw = 8'h00; correct_en = 1'b1;
    out_ready = 1'b1; clr_cnt = 1'b0;
    @(negedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sec_cnt", sec_cnt, 0);
    chk("rst_ded_cnt", ded_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      drain();
      #1;
      if (i == 1) chk("sec_cnt_after_ec", sec_cnt, 1);
      if (i == 4) chk("ded_cnt_after_ca", ded_cnt, 1);
    end

    // Back-to-back stream with consumer stalled on cycles 3..5.
    drv_clr = 1'b1; step(); drv_clr = 1'b0;
    sent = 0;
    n_out = 0;
    for (int c = 0; c < 40 && !(sent == 6 && exp_q.size() == 0); c++) begin
      drv_valid = (sent < 6);
      if (sent < 6) drv_vec = strm[sent];
      drv_ready = !(c >= 3 && c <= 5);
      step();
      if (accepted) sent++;
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    chk("stream_sent", sent, 6);
    chk("stream_out", n_out, 6);
    chk("stream_left", exp_q.size(), 0);

    // Counter saturation, then clear coinciding with a counted handshake.
    drv_clr = 1'b1; step(); drv_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(mk(enc(4'(i)) ^ 8'h40, 1'b1, 4'(i), 1'b1, 1'b0, 3'd6));
    drain();
    #1;
    chk("sec_sat", sec_cnt, 3);
    drv_ready = 1'b0;
    send(mk(enc(4'h5) ^ 8'h08, 1'b1, 4'h5, 1'b1, 1'b0, 3'd3));
    step();
    step();
    drv_ready = 1'b1;
    drv_clr   = 1'b1;
    step();
    drv_clr = 1'b0;
    #1;
    chk("clr_wins", sec_cnt, 0);
    drain();

    // Fill both stages, then reset mid-stream.
    send(mk(enc(4'h1) ^ 8'h02, 1'b1, 4'h1, 1'b1, 1'b0, 3'd1));
    drain();
    drv_ready = 1'b0;
    send(mk(enc(4'h7) ^ 8'h10, 1'b1, 4'h7, 1'b1, 1'b0, 3'd4));
    send(mk(enc(4'h9), 1'b1, 4'h9, 1'b0, 1'b0, 3'd0));
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sec_cnt", sec_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    m_sc = 0; m_dc = 0; held_v = 1'b0;
    drv_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    send(mk(8'hCC, 1'b1, 4'hB, 1'b0, 1'b0, 3'd0));
    drain();
    chk("latency", last_lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
